input_vc_ctrl: RTL and testbench

//  Per-input-VC controller; one instance per (input port, input VC), upstream of the VC input arbiters.

---
 rtl/router_pkg.sv | 55 +++++
 rtl/flit_fifo.sv | 65 ++++++
 rtl/input_vc_ctrl.sv | 142 ++++++++++++++
 tb/tb_input_vc_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// ---------------------------------------------------------------------------
// router_pkg
// Shared router types and sizes: port and VC counts, mesh coordinate width,
// the output direction encoding, the flit layout, the input-VC controller
// state encoding, and the XY routing helper.
// ---------------------------------------------------------------------------
package router_pkg;

   localparam int NUM_PORTS    = 5;
   localparam int NUM_VCS      = 4;
   localparam int VC_ID_BITS   = 2;
   localparam int DIM_BITS     = 4;
   localparam int PAYLOAD_BITS = 16;

   // The direction value doubles as the port index into the vc_grant,
   // grant_success and credit_ok arrays, so N..L must stay at 0..4.
   typedef enum logic [2:0] {
      DIR_N    = 3'd0,
      DIR_E    = 3'd1,
      DIR_S    = 3'd2,
      DIR_W    = 3'd3,
      DIR_L    = 3'd4,
      DIR_NONE = 3'd7
   } dir_t;

   typedef struct packed {
      logic                    head;
      logic                    tail;
      logic [DIM_BITS-1:0]     dest_x;
      logic [DIM_BITS-1:0]     dest_y;
      logic [PAYLOAD_BITS-1:0] payload;
   } flit_t;

   typedef enum logic [1:0] {
      IDLE,
      RC,
      VA,
      ACTIVE
   } ivc_state_t;

   // Dimension-ordered routing: X is resolved first, then Y, then eject locally.
   function automatic dir_t xy_route(input logic [DIM_BITS-1:0] dest_x,
                                     input logic [DIM_BITS-1:0] dest_y,
                                     input logic [DIM_BITS-1:0] local_x,
                                     input logic [DIM_BITS-1:0] local_y);
      dir_t dir;
      if (dest_x > local_x)      dir = DIR_E;
      else if (dest_x < local_x) dir = DIR_W;
      else if (dest_y > local_y) dir = DIR_N;
      else if (dest_y < local_y) dir = DIR_S;
      else                       dir = DIR_L;
      return dir;
   endfunction

endpackage

// File: rtl/flit_fifo.sv
// ---------------------------------------------------------------------------
// flit_fifo
// Circular flit buffer for one input VC.
// Ports:
//   clk, arst_n        clock, asynchronous active-low reset (empties buffer)
//   wr_en, wr_data     write strobe and flit; accepted when not full, or when
//                      a read happens in the same cycle
//   rd_en              pop the front flit (ignored when empty)
//   rd_data            front flit (meaningful only when not empty)
//   empty, full, count occupancy status
// ---------------------------------------------------------------------------
module flit_fifo
   import router_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   arst_n,
   input  logic                   wr_en,
   input  flit_t                  wr_data,
   input  logic                   rd_en,
   output flit_t                  rd_data,
   output logic                   empty,
   output logic                   full,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   flit_t             mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              push;
   logic              pop;

   // A write into a full buffer is still taken when the front is leaving in
   // the same cycle: the write lands in the slot being vacated.
   always_comb begin
      empty   = (count == '0);
      full    = (count == CNT_W'(DEPTH));
      pop     = rd_en && !empty;
      push    = wr_en && (!full || pop);
      rd_data = mem[rd_ptr];
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Storage needs no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/input_vc_ctrl.sv
// ---------------------------------------------------------------------------
// input_vc_ctrl
// Per-input-VC controller: buffers flits, XY-routes each head flit, requests
// an output VC, accepts one grant, then competes for the switch until the
// tail flit leaves.
// Ports:
//   clk, arst_n     clock, asynchronous active-low reset
//   in_valid/in_flit  flit write from the upstream link
//   credit_out      pulse when a buffer slot is freed
//   reqva           requested output port while waiting for a VC, else DIR_NONE
//   vc_grant        grants from every output-VC arbiter, indexed [port][vc]
//   grant_success   one-hot acceptance of a grant, same cycle as the grant
//   vc_unlock       pulse when the tail flit departs through the switch
//   credit_ok       downstream VC has at least one credit, indexed [port][vc]
//   sa_req/sa_gnt   switch request; the front flit is popped on the grant
//   out_flit        front flit of the buffer
//   out_port/out_vc output port and VC held for the packet in flight
// ---------------------------------------------------------------------------
module input_vc_ctrl
   import router_pkg::*;
#(
   parameter int                  BUF_DEPTH = 4,
   parameter logic [DIM_BITS-1:0] LOCAL_X   = '0,
   parameter logic [DIM_BITS-1:0] LOCAL_Y   = '0
) (
   input  logic                                 clk,
   input  logic                                 arst_n,
   input  logic                                 in_valid,
   input  flit_t                                in_flit,
   output logic                                 credit_out,
   output dir_t                                 reqva,
   input  logic [NUM_PORTS-1:0][NUM_VCS-1:0]    vc_grant,
   output logic [NUM_PORTS-1:0][NUM_VCS-1:0]    grant_success,
   output logic                                 vc_unlock,
   input  logic [NUM_PORTS-1:0][NUM_VCS-1:0]    credit_ok,
   output logic                                 sa_req,
   input  logic                                 sa_gnt,
   output flit_t                                out_flit,
   output dir_t                                 out_port,
   output logic [VC_ID_BITS-1:0]                out_vc
);

   localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

   ivc_state_t              state;
   flit_t                   front;
   logic                    empty;
   logic                    full;
   logic [CNT_W-1:0]        count;
   logic                    pop;
   logic                    sa_pop;
   logic                    orphan_pop;
   logic                    grant_found;
   logic [VC_ID_BITS-1:0]   grant_vc;
   dir_t                    route;

   flit_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
      .clk     (clk),
      .arst_n  (arst_n),
      .wr_en   (in_valid),
      .wr_data (in_flit),
      .rd_en   (pop),
      .rd_data (front),
      .empty   (empty),
      .full    (full),
      .count   (count)
   );

   // A body/tail flit at the front while idle has no packet to belong to, so
   // it is dropped and its slot returned upstream immediately.
   always_comb begin
      sa_req     = (state == ACTIVE) && !empty && credit_ok[out_port][out_vc];
      sa_pop     = sa_req && sa_gnt;
      orphan_pop = (state == IDLE) && !empty && !front.head;
      pop        = sa_pop || orphan_pop;
      credit_out = pop;
      vc_unlock  = sa_pop && front.tail;
      out_flit   = front;
      route      = xy_route(front.dest_x, front.dest_y, LOCAL_X, LOCAL_Y);
   end

   // Grant acceptance only looks at the requested port; the downward scan
   // leaves the lowest granted VC as the winner.
   always_comb begin
      grant_success = '0;
      grant_found   = 1'b0;
      grant_vc      = '0;
      if (state == VA) begin
         for (int v = NUM_VCS - 1; v >= 0; v--) begin
            if (vc_grant[out_port][v]) begin
               grant_found = 1'b1;
               grant_vc    = VC_ID_BITS'(v);
            end
         end
         if (grant_found) grant_success[out_port][grant_vc] = 1'b1;
      end
   end

   // Packet state machine. After a tail pop it goes straight back to RC when
   // another flit is buffered or arriving, so back-to-back packets lose no
   // idle cycle.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state    <= IDLE;
         reqva    <= DIR_NONE;
         out_port <= DIR_NONE;
         out_vc   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!empty && front.head) state <= RC;
            end
            RC: begin
               out_port <= route;
               reqva    <= route;
               state    <= VA;
            end
            VA: begin
               if (grant_found) begin
                  out_vc <= grant_vc;
                  reqva  <= DIR_NONE;
                  state  <= ACTIVE;
               end
            end
            ACTIVE: begin
               if (sa_pop && front.tail) begin
                  out_port <= DIR_NONE;
                  state    <= ((count > CNT_W'(1)) || in_valid) ? RC : IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Upstream credit protocol violations show up here in simulation.
   assert property (@(posedge clk) disable iff (!arst_n) !(in_valid && full && !pop))
      else $error("input_vc_ctrl: flit written into full buffer, dropped");
   assert property (@(posedge clk) disable iff (!arst_n) !orphan_pop)
      else $error("input_vc_ctrl: non-head flit at front while idle, discarded");

endmodule

// File: tb/tb_input_vc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_input_vc_ctrl
// Directed bench for input_vc_ctrl at LOCAL=(1,1): routing to every direction,
// grant selection and filtering, multi-flit and single-flit packets,
// back-to-back packets, credit stalls and mid-packet reset.
// ---------------------------------------------------------------------------
module tb_input_vc_ctrl;
   import router_pkg::*;

   logic                              clk = 1'b0;
   logic                              arst_n;
   logic                              in_valid;
   flit_t                             in_flit;
   logic                              credit_out;
   dir_t                              reqva;
   logic [NUM_PORTS-1:0][NUM_VCS-1:0] vc_grant;
   logic [NUM_PORTS-1:0][NUM_VCS-1:0] grant_success;
   logic                              vc_unlock;
   logic [NUM_PORTS-1:0][NUM_VCS-1:0] credit_ok;
   logic                              sa_req;
   logic                              sa_gnt;
   flit_t                             out_flit;
   dir_t                              out_port;
   logic [VC_ID_BITS-1:0]             out_vc;

   int assertCount = 0;
   int failCount   = 0;

   always #5 clk = ~clk;

   input_vc_ctrl #(
      .BUF_DEPTH (4),
      .LOCAL_X   (4'd1),
      .LOCAL_Y   (4'd1)
   ) dut (
      .clk           (clk),
      .arst_n        (arst_n),
      .in_valid      (in_valid),
      .in_flit       (in_flit),
      .credit_out    (credit_out),
      .reqva         (reqva),
      .vc_grant      (vc_grant),
      .grant_success (grant_success),
      .vc_unlock     (vc_unlock),
      .credit_ok     (credit_ok),
      .sa_req        (sa_req),
      .sa_gnt        (sa_gnt),
      .out_flit      (out_flit),
      .out_port      (out_port),
      .out_vc        (out_vc)
   );

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Let combinational outputs follow freshly driven inputs.
   task automatic settle();
      #1;
   endtask

   function automatic flit_t mkFlit(input logic h, input logic t,
                                    input logic [3:0] dx, input logic [3:0] dy,
                                    input logic [15:0] p);
      flit_t f;
      f.head    = h;
      f.tail    = t;
      f.dest_x  = dx;
      f.dest_y  = dy;
      f.payload = p;
      return f;
   endfunction

   // Link and switch-grant inputs move together in most steps.
   task automatic applyStimulus(input logic valid, input flit_t flit, input logic gnt);
      in_valid = valid;
      in_flit  = flit;
      sa_gnt   = gnt;
   endtask

   // One comparison: counted, and reported on mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assertCount++;
      assert (observed === expected)
         else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
         end
   endtask

   // Hold the grant bit for one port/VC pair as a flattened vector value.
   function automatic logic [31:0] gsBit(input dir_t p, input int v);
      return 32'(1) << (32'(p) * NUM_VCS + v);
   endfunction

   initial begin
      arst_n    = 1'b0;
      vc_grant  = '0;
      credit_ok = '1;
      applyStimulus(1'b0, '0, 1'b0);

      // Reset values while reset is held.
      tick();
      tick();
      checkOutput("rst_reqva",    32'(reqva),         32'(DIR_NONE));
      checkOutput("rst_out_port", 32'(out_port),      32'(DIR_NONE));
      checkOutput("rst_out_vc",   32'(out_vc),        32'd0);
      checkOutput("rst_sa_req",   32'(sa_req),        32'd0);
      checkOutput("rst_credit",   32'(credit_out),    32'd0);
      checkOutput("rst_unlock",   32'(vc_unlock),     32'd0);
      checkOutput("rst_gs",       32'(grant_success), 32'd0);
      arst_n = 1'b1;
      tick();

      $display("[TB] test 1: three-flit packet east, grant on E VC1");
      applyStimulus(1'b1, mkFlit(1'b1, 1'b0, 4'd3, 4'd1, 16'h0001), 1'b0);
      tick();
      applyStimulus(1'b1, mkFlit(1'b0, 1'b0, 4'd3, 4'd1, 16'h0002), 1'b0);
      settle();
      checkOutput("t1_idle_reqva", 32'(reqva), 32'(DIR_NONE));
      checkOutput("t1_idle_credit", 32'(credit_out), 32'd0);
      tick();
      applyStimulus(1'b1, mkFlit(1'b0, 1'b1, 4'd3, 4'd1, 16'h0003), 1'b0);
      settle();
      checkOutput("t1_rc_reqva", 32'(reqva), 32'(DIR_NONE));
      tick();
      applyStimulus(1'b0, '0, 1'b0);
      settle();
      checkOutput("t1_reqva", 32'(reqva), 32'(DIR_E));
      checkOutput("t1_gs_idle", 32'(grant_success), 32'd0);
      tick();
      checkOutput("t1_reqva_hold", 32'(reqva), 32'(DIR_E));
      tick();
      vc_grant[DIR_E][1] = 1'b1;
      settle();
      checkOutput("t1_gs", 32'(grant_success), gsBit(DIR_E, 1));
      checkOutput("t1_sa_req_va", 32'(sa_req), 32'd0);
      tick();
      vc_grant = '0;
      settle();
      checkOutput("t1_reqva_drop", 32'(reqva),    32'(DIR_NONE));
      checkOutput("t1_out_vc",     32'(out_vc),   32'd1);
      checkOutput("t1_out_port",   32'(out_port), 32'(DIR_E));
      checkOutput("t1_sa_req",     32'(sa_req),   32'd1);
      checkOutput("t1_flit0",      32'(out_flit.payload), 32'h0001);
      sa_gnt = 1'b1;
      settle();
      checkOutput("t1_pop0", 32'({credit_out, vc_unlock}), 32'b10);
      tick();
      checkOutput("t1_flit1", 32'(out_flit.payload), 32'h0002);
      checkOutput("t1_pop1", 32'({credit_out, vc_unlock}), 32'b10);
      tick();
      checkOutput("t1_flit2", 32'(out_flit.payload), 32'h0003);
      checkOutput("t1_pop2", 32'({credit_out, vc_unlock}), 32'b11);
      tick();
      sa_gnt = 1'b0;
      settle();
      checkOutput("t1_done_sa_req",   32'(sa_req),     32'd0);
      checkOutput("t1_done_out_port", 32'(out_port),   32'(DIR_NONE));
      checkOutput("t1_done_credit",   32'(credit_out), 32'd0);

      $display("[TB] test 2: single-flit packet to local port");
      applyStimulus(1'b1, mkFlit(1'b1, 1'b1, 4'd1, 4'd1, 16'h0010), 1'b0);
      tick();
      applyStimulus(1'b0, '0, 1'b0);
      tick();
      tick();
      checkOutput("t2_reqva", 32'(reqva), 32'(DIR_L));
      vc_grant[DIR_L][0] = 1'b1;
      settle();
      checkOutput("t2_gs", 32'(grant_success), gsBit(DIR_L, 0));
      tick();
      vc_grant = '0;
      settle();
      checkOutput("t2_sa_req", 32'(sa_req), 32'd1);
      sa_gnt = 1'b1;
      settle();
      checkOutput("t2_pop", 32'({credit_out, vc_unlock}), 32'b11);
      tick();
      sa_gnt = 1'b0;
      settle();
      checkOutput("t2_done_sa_req",   32'(sa_req),   32'd0);
      checkOutput("t2_done_out_port", 32'(out_port), 32'(DIR_NONE));

      $display("[TB] test 3: grant filtering on north request");
      applyStimulus(1'b1, mkFlit(1'b1, 1'b1, 4'd1, 4'd3, 16'h0020), 1'b0);
      tick();
      applyStimulus(1'b0, '0, 1'b0);
      tick();
      tick();
      checkOutput("t3_reqva", 32'(reqva), 32'(DIR_N));
      vc_grant[DIR_E][0] = 1'b1;
      settle();
      checkOutput("t3_gs_other_port", 32'(grant_success), 32'd0);
      tick();
      checkOutput("t3_reqva_hold", 32'(reqva), 32'(DIR_N));
      vc_grant[DIR_N][0] = 1'b1;
      vc_grant[DIR_N][2] = 1'b1;
      vc_grant[DIR_E][1] = 1'b1;
      settle();
      checkOutput("t3_gs_lowest", 32'(grant_success), gsBit(DIR_N, 0));
      tick();
      vc_grant = '0;
      settle();
      checkOutput("t3_out_vc", 32'(out_vc), 32'd0);
      checkOutput("t3_reqva_drop", 32'(reqva), 32'(DIR_NONE));
      sa_gnt = 1'b1;
      tick();
      sa_gnt = 1'b0;
      settle();
      checkOutput("t3_done_sa_req", 32'(sa_req), 32'd0);

      $display("[TB] test 4: back-to-back packets west then south");
      applyStimulus(1'b1, mkFlit(1'b1, 1'b1, 4'd0, 4'd1, 16'h0030), 1'b0);
      tick();
      applyStimulus(1'b1, mkFlit(1'b1, 1'b1, 4'd1, 4'd0, 16'h0031), 1'b0);
      tick();
      applyStimulus(1'b0, '0, 1'b0);
      tick();
      checkOutput("t4_reqva_a", 32'(reqva), 32'(DIR_W));
      vc_grant[DIR_W][3] = 1'b1;
      settle();
      checkOutput("t4_gs_a", 32'(grant_success), gsBit(DIR_W, 3));
      tick();
      vc_grant = '0;
      sa_gnt   = 1'b1;
      settle();
      checkOutput("t4_flit_a", 32'(out_flit.payload), 32'h0030);
      checkOutput("t4_unlock_a", 32'(vc_unlock), 32'd1);
      tick();
      sa_gnt = 1'b0;
      settle();
      checkOutput("t4_rc_reqva", 32'(reqva),  32'(DIR_NONE));
      checkOutput("t4_rc_sa_req", 32'(sa_req), 32'd0);
      checkOutput("t4_flit_b", 32'(out_flit.payload), 32'h0031);
      tick();
      checkOutput("t4_reqva_b", 32'(reqva), 32'(DIR_S));
      vc_grant[DIR_S][1] = 1'b1;
      settle();
      checkOutput("t4_gs_b", 32'(grant_success), gsBit(DIR_S, 1));
      tick();
      vc_grant = '0;
      settle();
      checkOutput("t4_out_vc_b", 32'(out_vc), 32'd1);
      sa_gnt = 1'b1;
      tick();
      sa_gnt = 1'b0;

      $display("[TB] test 5: downstream credit stall mid-packet");
      applyStimulus(1'b1, mkFlit(1'b1, 1'b0, 4'd2, 4'd1, 16'h0040), 1'b0);
      tick();
      applyStimulus(1'b1, mkFlit(1'b0, 1'b0, 4'd2, 4'd1, 16'h0041), 1'b0);
      tick();
      applyStimulus(1'b1, mkFlit(1'b0, 1'b1, 4'd2, 4'd1, 16'h0042), 1'b0);
      tick();
      applyStimulus(1'b0, '0, 1'b0);
      settle();
      checkOutput("t5_reqva", 32'(reqva), 32'(DIR_E));
      vc_grant[DIR_E][2] = 1'b1;
      tick();
      vc_grant = '0;
      settle();
      checkOutput("t5_out_vc", 32'(out_vc), 32'd2);
      sa_gnt = 1'b1;
      tick();
      credit_ok[DIR_E][2] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         settle();
         checkOutput($sformatf("t5_stall_sa_req%0d", i), 32'(sa_req),     32'd0);
         checkOutput($sformatf("t5_stall_credit%0d", i), 32'(credit_out), 32'd0);
         tick();
      end
      credit_ok[DIR_E][2] = 1'b1;
      settle();
      checkOutput("t5_resume_sa_req", 32'(sa_req), 32'd1);
      checkOutput("t5_resume_flit",   32'(out_flit.payload), 32'h0041);
      checkOutput("t5_resume_pop",    32'({credit_out, vc_unlock}), 32'b10);
      tick();
      checkOutput("t5_tail_flit", 32'(out_flit.payload), 32'h0042);
      checkOutput("t5_tail_pop",  32'({credit_out, vc_unlock}), 32'b11);
      tick();
      sa_gnt = 1'b0;
      settle();
      checkOutput("t5_done_sa_req", 32'(sa_req), 32'd0);

      $display("[TB] test 6: reset while active with two flits buffered");
      applyStimulus(1'b1, mkFlit(1'b1, 1'b0, 4'd1, 4'd2, 16'h0050), 1'b0);
      tick();
      applyStimulus(1'b1, mkFlit(1'b0, 1'b0, 4'd1, 4'd2, 16'h0051), 1'b0);
      tick();
      applyStimulus(1'b1, mkFlit(1'b0, 1'b1, 4'd1, 4'd2, 16'h0052), 1'b0);
      tick();
      applyStimulus(1'b0, '0, 1'b0);
      settle();
      checkOutput("t6_reqva", 32'(reqva), 32'(DIR_N));
      vc_grant[DIR_N][3] = 1'b1;
      tick();
      vc_grant = '0;
      sa_gnt   = 1'b1;
      tick();
      sa_gnt = 1'b0;
      settle();
      checkOutput("t6_active_sa_req", 32'(sa_req), 32'd1);
      arst_n = 1'b0;
      settle();
      checkOutput("t6_rst_reqva",    32'(reqva),         32'(DIR_NONE));
      checkOutput("t6_rst_out_port", 32'(out_port),      32'(DIR_NONE));
      checkOutput("t6_rst_out_vc",   32'(out_vc),        32'd0);
      checkOutput("t6_rst_sa_req",   32'(sa_req),        32'd0);
      checkOutput("t6_rst_credit",   32'(credit_out),    32'd0);
      checkOutput("t6_rst_unlock",   32'(vc_unlock),     32'd0);
      checkOutput("t6_rst_gs",       32'(grant_success), 32'd0);
      tick();
      arst_n = 1'b1;
      tick();
      checkOutput("t6_post_sa_req", 32'(sa_req),     32'd0);
      checkOutput("t6_post_credit", 32'(credit_out), 32'd0);
      tick();
      checkOutput("t6_post_credit2", 32'(credit_out), 32'd0);
      tick();
      tick();
      checkOutput("t6_post_reqva", 32'(reqva), 32'(DIR_NONE));

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
